// File: rtl/niosqs_nios2_qsys_0_oci_dct_capture_if.sv
// DCT capture bus: trace-word input, stop controls, and the registered drain/status port.
// OCI_DCT_TIMESTAMP_EN widens rd_data by a 16-bit timestamp field.
interface niosqs_nios2_qsys_0_oci_dct_capture_if #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
`ifdef OCI_DCT_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int RD_W = TS_W + CNT_W + DATA_W;

    logic [DATA_W-1:0] dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              dct_valid;
    logic              test_ending;
    logic              test_has_ended;
    logic              rd_req;
    logic [RD_W-1:0]   rd_data;
    logic              rd_valid;
    logic [AW:0]       level;
    logic              empty;
    logic              overflow;
    logic              frozen;
    logic              done;

    modport master (
        output dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, rd_req,
        input  rd_data, rd_valid, level, empty, overflow, frozen, done
    );

    modport slave (
        input  dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, rd_req,
        output rd_data, rd_valid, level, empty, overflow, frozen, done
    );
endinterface

// File: rtl/niosqs_nios2_qsys_0_oci_dct_capture.sv
// DCT trace recorder: DEPTH-entry circular buffer with overwrite-on-full, freeze on test end,
// registered drain port. Define OCI_DCT_TIMESTAMP_EN to tag each entry with a 16-bit cycle stamp.
module niosqs_nios2_qsys_0_oci_dct_capture #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic reset_n,
    niosqs_nios2_qsys_0_oci_dct_capture_if.slave bus
);
`ifdef OCI_DCT_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int ENT_W = TS_W + CNT_W + DATA_W;

    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

    state_t            state;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_p0;
    logic [ENT_W-1:0]  rd_data_p1;
    logic              vld_p1;
    logic              overflow_r;
    logic              frozen_r;
    logic              done_r;

    logic              stop_req;
    logic              full;
    logic              wr_en;
    logic              pop;
    logic              drop;
    logic [ENT_W-1:0]  entry;

`ifdef OCI_DCT_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 16'd1;
    end

    assign entry = {ts_cnt, bus.dct_count, bus.dct_buffer};
`else
    assign entry = {bus.dct_count, bus.dct_buffer};
`endif

    // A stop request discards any write presented on the same cycle.
    always_comb begin
        stop_req = bus.test_ending | bus.test_has_ended;
        full     = (level_p0 == (AW+1)'(DEPTH));
        wr_en    = (state == CAPTURE) && !stop_req && bus.dct_valid && (bus.dct_count != '0);
        pop      = bus.rd_req && (level_p0 != '0) && (state != DONE);
        drop     = wr_en && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= entry;
    end

    // p0: buffer bookkeeping; p1: registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_p0   <= '0;
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            overflow_r <= 1'b0;
            frozen_r   <= 1'b0;
            done_r     <= 1'b0;
            state      <= CAPTURE;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            // On overwrite the read pointer is dragged along so the oldest entry is lost.
            if (pop || drop) rd_ptr <= rd_ptr + 1'b1;

            if (wr_en && !pop && !full)
                level_p0 <= level_p0 + 1'b1;
            else if (pop && !wr_en)
                level_p0 <= level_p0 - 1'b1;

            vld_p1 <= pop;
            if (pop) rd_data_p1 <= mem[rd_ptr];

            if (drop) overflow_r <= 1'b1;

            case (state)
                CAPTURE: if (stop_req) begin
                    state    <= DRAIN;
                    frozen_r <= 1'b1;
                end
                DRAIN: if (bus.test_has_ended && (level_p0 == '0)) begin
                    state  <= DONE;
                    done_r <= 1'b1;
                end
                DONE:    state <= DONE;
                default: state <= CAPTURE;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.level    = level_p0;
    assign bus.empty    = (level_p0 == '0);
    assign bus.overflow = overflow_r;
    assign bus.frozen   = frozen_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_niosqs_nios2_qsys_0_oci_dct_capture.sv
// Bench for the DCT capture recorder: directed scenarios plus random traffic against a queue model.
module tb_niosqs_nios2_qsys_0_oci_dct_capture;
    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    niosqs_nios2_qsys_0_oci_dct_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus();

    niosqs_nios2_qsys_0_oci_dct_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffer is simply a FIFO queue of whole entries.
    logic [63:0] q[$];
    logic [63:0] m_rd;
    bit          m_rv, m_ovf, m_frz, m_done;
    int          m_ts;

    function automatic logic [63:0] mk(int ts, logic [CNT_W-1:0] c, logic [DATA_W-1:0] p);
        logic [63:0] e;
        e = (64'(c) << DATA_W) | 64'(p);
`ifdef OCI_DCT_TIMESTAMP_EN
        e = e | (64'(ts & 16'hFFFF) << (CNT_W + DATA_W));
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rd_valid", 64'(bus.rd_valid), 64'(m_rv));
        chk("rd_data",  64'(bus.rd_data),  m_rd);
        chk("level",    64'(bus.level),    64'(q.size()));
        chk("empty",    64'(bus.empty),    64'(q.size() == 0));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("frozen",   64'(bus.frozen),   64'(m_frz));
        chk("done",     64'(bus.done),     64'(m_done));
    endtask

    task automatic drive(bit v, int c, logic [DATA_W-1:0] p, bit rr, bit te, bit th);
        bus.dct_valid      = v;
        bus.dct_count      = CNT_W'(c);
        bus.dct_buffer     = p;
        bus.rd_req         = rr;
        bus.test_ending    = te;
        bus.test_has_ended = th;
    endtask

    task automatic step();
        bit do_pop, do_wr, nxt_done;
        @(posedge clk);
        do_pop   = bus.rd_req && (q.size() > 0) && !m_done;
        do_wr    = !m_frz && !bus.test_ending && !bus.test_has_ended
                   && bus.dct_valid && (bus.dct_count != 0);
        nxt_done = m_frz && bus.test_has_ended && (q.size() == 0);
        m_rv = do_pop;
        if (do_pop) m_rd = q.pop_front();
        if (do_wr) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
            q.push_back(mk(m_ts, bus.dct_count, bus.dct_buffer));
        end
        if (bus.test_ending || bus.test_has_ended) m_frz = 1'b1;
        if (nxt_done) m_done = 1'b1;
        m_ts = (m_ts + 1) & 16'hFFFF;
        #1 check_outputs();
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0, 0, 0);
        reset_n = 1'b0;
        q.delete();
        m_rd = '0; m_rv = 0; m_ovf = 0; m_frz = 0; m_done = 0; m_ts = 0;
        #1 check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] r0, r1;
        drive(0, 0, '0, 0, 0, 0);
        #2 do_reset();

        // Three writes then three pops, in order.
        for (int i = 1; i <= 3; i++) begin drive(1, 4, DATA_W'(i), 0, 0, 0); step(); end
        for (int i = 0; i < 3; i++)  begin drive(0, 0, '0, 1, 0, 0); step(); end
        drive(0, 0, '0, 0, 0, 0); step();

        // Overwrite: 20 writes into 16 entries, then drain all 16.
        for (int i = 0; i < 20; i++) begin drive(1, 1, DATA_W'(i), 0, 0, 0); step(); end
        for (int i = 0; i < 16; i++) begin drive(0, 0, '0, 1, 0, 0); step(); end
        drive(0, 0, '0, 1, 0, 0); step();

        // Full buffer, simultaneous write and pop: no overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin drive(1, 2, DATA_W'($urandom), 0, 0, 0); step(); end
        drive(1, 3, DATA_W'(30'h155), 1, 0, 0); step();
        drive(0, 0, '0, 0, 0, 0); step();

        // Zero count is ignored; pop on empty returns nothing.
        do_reset();
        drive(1, 0, DATA_W'(30'h3FF), 0, 0, 0); step();
        drive(0, 0, '0, 1, 0, 0); step();
        drive(1, 0, DATA_W'(30'h1), 1, 0, 0); step();

        // Asynchronous reset mid-capture with level 5 and overflow set.
        do_reset();
        for (int i = 0; i < 20; i++) begin drive(1, 1, DATA_W'(i), 0, 0, 0); step(); end
        for (int i = 0; i < 11; i++) begin drive(0, 0, '0, 1, 0, 0); step(); end
        drive(0, 0, '0, 0, 0, 0); step();
        chk("lvl5_before_reset", 64'(bus.level), 64'd5);
        do_reset();

`ifdef OCI_DCT_TIMESTAMP_EN
        // Writes on cycles 10 and 13 after reset carry stamps 3 apart.
        for (int i = 1; i <= 13; i++) begin
            drive((i == 10) || (i == 13), 1, DATA_W'(i), 0, 0, 0);
            step();
        end
        drive(0, 0, '0, 1, 0, 0); step(); r0 = 64'(bus.rd_data);
        step(); r1 = 64'(bus.rd_data);
        chk("ts_delta", (r1 >> (CNT_W + DATA_W)) - (r0 >> (CNT_W + DATA_W)), 64'd3);
        drive(0, 0, '0, 0, 0, 0); step();
`else
        r0 = '0; r1 = '0;
`endif

        // Random traffic: write-heavy half then pop-heavy half.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), DATA_W'($urandom),
                  ($urandom_range(0, 99) < ((i < 200) ? 25 : 75)), 0, 0);
            step();
        end

        // Freeze: two writes, stop request with a write, a late write, then drain to done.
        do_reset();
        drive(1, 5, DATA_W'(30'hA), 0, 0, 0); step();
        drive(1, 6, DATA_W'(30'hB), 0, 0, 0); step();
        drive(1, 7, DATA_W'(30'hC), 0, 1, 0); step();
        drive(1, 8, DATA_W'(30'hD), 0, 0, 0); step();
        chk("frozen_level", 64'(bus.level), 64'd2);
        drive(0, 0, '0, 1, 0, 1); step();
        step();
        drive(0, 0, '0, 0, 0, 1); step();
        chk("done_after_drain", 64'(bus.done), 64'd1);
        drive(1, 3, DATA_W'(30'h7), 1, 0, 1); step();
        drive(0, 0, '0, 1, 0, 0); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
